// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-master memory arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   localparam logic M_CPU = 1'b0;
   localparam logic M_AUX = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-way round-robin grant; priority flips to the loser of every grant
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_prio,
   input  logic       i_en,
   output logic [1:0] o_grant,
   output logic       o_next_prio
);

   always_comb begin
      o_grant = 2'b00;
      if (i_en) begin
         if (&i_req) begin
            o_grant = (i_prio == M_AUX) ? 2'b10 : 2'b01;
         end else begin
            o_grant = i_req;
         end
      end
      o_next_prio = i_prio;
      if (o_grant[M_CPU]) begin
         o_next_prio = M_AUX;
      end else if (o_grant[M_AUX]) begin
         o_next_prio = M_CPU;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between CPU and loader/DMA with wait-state timeout
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              iClk,
   input  logic              nRst,
   input  logic              iRd0,
   input  logic              iWr0,
   input  logic [ADDR_W-1:0] iAddr0,
   input  logic [DATA_W-1:0] iWData0,
   output logic [DATA_W-1:0] oRData0,
   output logic              oDone0,
   input  logic              iRd1,
   input  logic              iWr1,
   input  logic [ADDR_W-1:0] iAddr1,
   input  logic [DATA_W-1:0] iWData1,
   output logic [DATA_W-1:0] oRData1,
   output logic              oDone1,
   output logic              oErr,
   output logic [ADDR_W-1:0] oMemAddr,
   output logic [DATA_W-1:0] oMemData,
   output logic              oMemRead,
   output logic              oMemWrite,
   input  logic [DATA_W-1:0] iMemData,
   input  logic              iMemReady
);

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   state_t            r_state;
   op_t               r_op;
   logic              r_gnt;
   logic              r_prio;
   logic [7:0]        r_cnt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_data;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic [DATA_W-1:0] r_rdata;
   logic              r_done0;
   logic              r_done1;
   logic              r_err;

   logic [1:0]        w_req;
   logic [1:0]        w_grant;
   logic              w_next_prio;
   logic              w_sel;
   op_t               w_op;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_fin;

   assign w_req   = {iRd1 | iWr1, iRd0 | iWr0};
   assign w_sel   = w_grant[M_AUX];
   assign w_op    = (w_sel ? iWr1 : iWr0) ? OP_WR : OP_RD;
   assign w_addr  = w_sel ? iAddr1 : iAddr0;
   assign w_wdata = w_sel ? iWData1 : iWData0;
   // An access ends on ready or once the wait budget is exhausted
   assign w_fin   = (r_state == BUSY) && (iMemReady || (r_cnt == TO_LIMIT));

   arb_rr2 u_arb (
      .i_req       (w_req),
      .i_prio      (r_prio),
      .i_en        (r_state == IDLE),
      .o_grant     (w_grant),
      .o_next_prio (w_next_prio)
   );

   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         r_state    <= IDLE;
         r_op       <= OP_RD;
         r_gnt      <= M_CPU;
         r_prio     <= M_CPU;
         r_cnt      <= '0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
         r_mem_rd   <= 1'b0;
         r_mem_wr   <= 1'b0;
         r_rdata    <= '0;
         r_done0    <= 1'b0;
         r_done1    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|w_grant) begin
                  r_gnt      <= w_sel;
                  r_prio     <= w_next_prio;
                  r_op       <= w_op;
                  r_mem_addr <= w_addr;
                  r_mem_data <= (w_op == OP_WR) ? w_wdata : '0;
                  r_mem_rd   <= (w_op == OP_RD);
                  r_mem_wr   <= (w_op == OP_WR);
                  r_cnt      <= '0;
                  r_state    <= BUSY;
               end
            end
            BUSY: begin
               if (w_fin) begin
                  if (iMemReady) begin
                     if (r_op == OP_RD) begin
                        r_rdata <= iMemData;
                     end
                     r_err <= 1'b0;
                  end else begin
                     r_rdata <= '0;
                     r_err   <= 1'b1;
                  end
                  r_mem_rd <= 1'b0;
                  r_mem_wr <= 1'b0;
                  r_done0  <= (r_gnt == M_CPU);
                  r_done1  <= (r_gnt == M_AUX);
                  r_state  <= DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            DONE: begin
               r_done0 <= 1'b0;
               r_done1 <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign oRData0   = r_rdata;
   assign oRData1   = r_rdata;
   assign oDone0    = r_done0;
   assign oDone1    = r_done1;
   assign oErr      = r_err;
   assign oMemAddr  = r_mem_addr;
   assign oMemData  = r_mem_data;
   assign oMemRead  = r_mem_rd;
   assign oMemWrite = r_mem_wr;

endmodule
